// File: rtl/decode_queue_pkg.sv
// Shared definitions for the decode output queue: decoded-entry field
// widths, field offsets (LSB positions inside one entry), the functional
// unit IDs and small helpers for pulling fields out of a packed entry.
package decode_queue_pkg;

    // Field widths, listed MSB first as they sit in an entry.
    localparam int OpcodeWidth    = 12;
    localparam int AddrWidth      = 64;
    localparam int UnitWidth      = 3;
    localparam int MajorIdWidth   = 64;
    localparam int MinorIdWidth   = 7;
    localparam int MicroOpWidth   = 7;
    localparam int Is64BitWidth   = 1;
    localparam int PidWidth       = 20;
    localparam int TidWidth       = 16;
    localparam int RwWidth        = 2;
    localparam int FlagWidth      = 1;
    localparam int BodyWidth      = 26;

    // Total entry width derived from the field list (229 bits).
    localparam int QueueEntryWidth = OpcodeWidth + AddrWidth + UnitWidth
                                   + MajorIdWidth + MinorIdWidth + MicroOpWidth
                                   + Is64BitWidth + PidWidth + TidWidth
                                   + 2 * RwWidth + 5 * FlagWidth + BodyWidth;

    // Field LSB offsets, built bottom-up from the body field.
    localparam int BodyLsb         = 0;
    localparam int ModifiesCrLsb   = BodyLsb + BodyWidth;
    localparam int ImmShiftedLsb   = ModifiesCrLsb + FlagWidth;
    localparam int ImmExtendedLsb  = ImmShiftedLsb + FlagWidth;
    localparam int Op2IsRegLsb     = ImmExtendedLsb + FlagWidth;
    localparam int Op1IsRegLsb     = Op2IsRegLsb + FlagWidth;
    localparam int Op2RwLsb        = Op1IsRegLsb + FlagWidth;
    localparam int Op1RwLsb        = Op2RwLsb + RwWidth;
    localparam int TidLsb          = Op1RwLsb + RwWidth;
    localparam int PidLsb          = TidLsb + TidWidth;
    localparam int Is64BitLsb      = PidLsb + PidWidth;
    localparam int MicroOpLsb      = Is64BitLsb + Is64BitWidth;
    localparam int MinorIdLsb      = MicroOpLsb + MicroOpWidth;
    localparam int MajorIdLsb      = MinorIdLsb + MinorIdWidth;
    localparam int UnitLsb         = MajorIdLsb + MajorIdWidth;
    localparam int AddrLsb         = UnitLsb + UnitWidth;
    localparam int OpcodeLsb       = AddrLsb + AddrWidth;

    // Functional unit identifiers carried in the unit field.
    typedef enum logic [UnitWidth-1:0] {
        UnitFx     = 3'd0,
        UnitFp     = 3'd1,
        UnitVx     = 3'd2,
        UnitCr     = 3'd3,
        UnitLs     = 3'd4,
        UnitBranch = 3'd6
    } unit_e;

    // Structured view of one entry; the packed layout matches the offsets above.
    typedef struct packed {
        logic [OpcodeWidth-1:0]  opcode;
        logic [AddrWidth-1:0]    address;
        logic [UnitWidth-1:0]    unit;
        logic [MajorIdWidth-1:0] majorId;
        logic [MinorIdWidth-1:0] minorId;
        logic [MicroOpWidth-1:0] numMicroOps;
        logic                    is64Bit;
        logic [PidWidth-1:0]     pid;
        logic [TidWidth-1:0]     tid;
        logic [RwWidth-1:0]      op1rw;
        logic [RwWidth-1:0]      op2rw;
        logic                    op1isReg;
        logic                    op2isReg;
        logic                    immIsExtended;
        logic                    immIsShifted;
        logic                    modifiesCR;
        logic [BodyWidth-1:0]    body;
    } entry_t;

    // Extract the opcode field from a flat entry.
    function automatic logic [OpcodeWidth-1:0] entryOpcode(
        input logic [QueueEntryWidth-1:0] entry
    );
        return entry[OpcodeLsb +: OpcodeWidth];
    endfunction

    // Extract the functional unit field from a flat entry.
    function automatic logic [UnitWidth-1:0] entryUnit(
        input logic [QueueEntryWidth-1:0] entry
    );
        return entry[UnitLsb +: UnitWidth];
    endfunction

endpackage

// File: rtl/decode_input_select.sv
// Input selector for the decode output queue. Reduces the per-decoder
// enable vector and the concatenated data bus to one push request.
// The lowest set enable wins the mux; a multi-hot vector is reported on
// collision_o. With DECODE_OUTPUT_QUEUE_COLLISION_CHECK_EN defined a
// multi-hot vector produces no push at all.
module decode_input_select #(
    parameter int NumDecoders = 25,
    parameter int EntryWidth  = 229
) (
    input  logic [NumDecoders-1:0]            dec_enable_i,
    input  logic [NumDecoders*EntryWidth-1:0] dec_data_i,
    output logic                              push_valid_o,
    output logic [EntryWidth-1:0]             push_data_o,
    output logic                              collision_o
);

    logic anyEnable;
    logic multiHot;

    // Walk from the top index down so the lowest set enable is the last write.
    always_comb begin
        push_data_o = '0;
        for (int i = NumDecoders - 1; i >= 0; i--) begin
            if (dec_enable_i[i]) begin
                push_data_o = dec_data_i[i*EntryWidth +: EntryWidth];
            end
        end
    end

    // Clearing the lowest set bit leaves something only when two or more bits are set.
    always_comb begin
        anyEnable = |dec_enable_i;
        multiHot  = |(dec_enable_i & (dec_enable_i - NumDecoders'(1)));
    end

    // Decide whether the selected slice becomes a push.
    always_comb begin
        collision_o = multiHot;
`ifdef DECODE_OUTPUT_QUEUE_COLLISION_CHECK_EN
        push_valid_o = anyEnable && !multiHot;
`else
        push_valid_o = anyEnable;
`endif
    end

endmodule

// File: rtl/decode_output_queue.sv
// Decode output queue: in-order first-word-fall-through FIFO between the
// format decoder bank and issue/rename. At most one decoder should be
// enabled per cycle; the queue back-pressures all decoders through stall_o
// while StallMargin slots are still free, so the entries already in flight
// from the registered decoder outputs can still land.
// Optional feature macro: DECODE_OUTPUT_QUEUE_COLLISION_CHECK_EN
// (multi-hot enables push nothing and set the sticky collision_o).
module decode_output_queue
    import decode_queue_pkg::*;
#(
    parameter int NumDecoders = 25,
    parameter int EntryWidth  = QueueEntryWidth,
    parameter int Depth       = 8,
    parameter int StallMargin = 2
) (
    input  logic                              clock_i,
    input  logic                              reset_i,
    input  logic [NumDecoders-1:0]            dec_enable_i,
    input  logic [NumDecoders*EntryWidth-1:0] dec_data_i,
    input  logic                              flush_i,
    output logic                              stall_o,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic [EntryWidth-1:0]             data_o,
    output logic [$clog2(Depth+1)-1:0]        count_o,
    output logic                              overflow_o,
    output logic                              collision_o
);

    localparam int PtrWidth   = $clog2(Depth);
    localparam int CountWidth = $clog2(Depth + 1);
    localparam logic [CountWidth-1:0] DepthCount = CountWidth'(Depth);
    localparam logic [CountWidth-1:0] StallLevel = CountWidth'(Depth - StallMargin);

    logic                  selValid;
    logic [EntryWidth-1:0] selData;
    logic                  selCollision;

    logic [EntryWidth-1:0] mem_q [Depth];
    logic [PtrWidth-1:0]   wrPtr_q, wrPtr_d;
    logic [PtrWidth-1:0]   rdPtr_q, rdPtr_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  collision_q, collision_d;

    logic isFull;
    logic popFire;
    logic pushAttempt;
    logic pushFire;
    logic dropOnFull;

    decode_input_select #(
        .NumDecoders (NumDecoders),
        .EntryWidth  (EntryWidth)
    ) u_input_select (
        .dec_enable_i (dec_enable_i),
        .dec_data_i   (dec_data_i),
        .push_valid_o (selValid),
        .push_data_o  (selData),
        .collision_o  (selCollision)
    );

    // Handshake decode: a push may use the slot freed by a same-cycle pop; flush cancels both.
    always_comb begin
        isFull      = (count_q == DepthCount);
        popFire     = (count_q != '0) && ready_i && !flush_i;
        pushAttempt = selValid && !flush_i;
        pushFire    = pushAttempt && (!isFull || popFire);
        dropOnFull  = pushAttempt && isFull && !popFire;
    end

    // Next pointers and occupancy; pointers wrap naturally since Depth is a power of two.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (pushFire) begin
                wrPtr_d = wrPtr_q + PtrWidth'(1);
            end
            if (popFire) begin
                rdPtr_d = rdPtr_q + PtrWidth'(1);
            end
            count_d = count_q + CountWidth'(pushFire) - CountWidth'(popFire);
        end
    end

    // Sticky flags only ever set here; reset is the sole way to clear them.
    always_comb begin
        overflow_d = overflow_q | dropOnFull;
`ifdef DECODE_OUTPUT_QUEUE_COLLISION_CHECK_EN
        collision_d = collision_q | selCollision;
`else
        collision_d = 1'b0;
`endif
    end

`ifndef DECODE_OUTPUT_QUEUE_COLLISION_CHECK_EN
    logic unusedCollision;
    assign unusedCollision = selCollision;
`endif

    // State registers and storage; reset also zeroes storage so data_o reads 0 afterwards.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            collision_q <= 1'b0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            collision_q <= collision_d;
            if (pushFire) begin
                mem_q[wrPtr_q] <= selData;
            end
        end
    end

    // Outputs come straight from registered state; the head is read combinationally.
    always_comb begin
        valid_o     = (count_q != '0);
        data_o      = mem_q[rdPtr_q];
        count_o     = count_q;
        stall_o     = (count_q >= StallLevel);
        overflow_o  = overflow_q;
        collision_o = collision_q;
    end

endmodule

// File: tb/tb_decode_output_queue.sv
// Testbench for decode_output_queue: a directed vector table covering the
// fill/stall/overflow/drain/flush/multi-hot/reset corners, followed by
// randomized traffic, with every cycle also compared against a queue-based
// reference model of the FIFO rules.
module tb_decode_output_queue;
    import decode_queue_pkg::*;

    localparam int NumDecoders = 25;
    localparam int EntryWidth  = QueueEntryWidth;
    localparam int Depth       = 8;
    localparam int StallMargin = 2;
    localparam int CountWidth  = $clog2(Depth + 1);
    localparam int RandomCycles = 600;

`ifdef DECODE_OUTPUT_QUEUE_COLLISION_CHECK_EN
    localparam logic ColOn = 1'b1;
`else
    localparam logic ColOn = 1'b0;
`endif

    logic                              clock_i;
    logic                              reset_i;
    logic [NumDecoders-1:0]            dec_enable_i;
    logic [NumDecoders*EntryWidth-1:0] dec_data_i;
    logic                              flush_i;
    logic                              stall_o;
    logic                              valid_o;
    logic                              ready_i;
    logic [EntryWidth-1:0]             data_o;
    logic [CountWidth-1:0]             count_o;
    logic                              overflow_o;
    logic                              collision_o;

    decode_output_queue #(
        .NumDecoders (NumDecoders),
        .EntryWidth  (EntryWidth),
        .Depth       (Depth),
        .StallMargin (StallMargin)
    ) dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .dec_enable_i (dec_enable_i),
        .dec_data_i   (dec_data_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .data_o       (data_o),
        .count_o      (count_o),
        .overflow_o   (overflow_o),
        .collision_o  (collision_o)
    );

    // Free-running clock.
    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    // Reference model state: contents in arrival order plus sticky flags.
    logic [EntryWidth-1:0] modelQ[$];
    logic                  modelOvf;
    logic                  modelCol;

    int compared;
    int mismatched;

    typedef struct {
        logic [NumDecoders-1:0] en;
        logic [11:0]            opc;
        logic                   flush;
        logic                   ready;
        logic                   rst;
        int                     expCount;
        logic                   expStall;
        logic                   expOvf;
        logic                   expCol;
        logic                   chkHead;
        logic [11:0]            expHead;
        logic                   expZeroData;
    } vec_t;

    vec_t vecs[$];

    // One comparison: count it, and report it when it differs.
    task automatic checkOutput(input string name, input logic [EntryWidth-1:0] actual,
                               input logic [EntryWidth-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // 229 random bits built from 32-bit draws.
    function automatic logic [EntryWidth-1:0] randomEntry();
        logic [255:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        return r[EntryWidth-1:0];
    endfunction

    // Drive one cycle of inputs, advance the model by the queue rules, then settle past the edge.
    task automatic applyStimulus(input logic [NumDecoders-1:0] en, input logic [11:0] opc,
                                 input logic flush, input logic ready, input logic rst);
        int lowest;
        int ones;
        logic [EntryWidth-1:0] slice;
        logic [EntryWidth-1:0] chosen;
        logic willPush;
        logic popNow;
        logic fullNow;
        @(negedge clock_i);
        lowest = -1;
        ones = 0;
        chosen = '0;
        for (int i = 0; i < NumDecoders; i++) begin
            if (en[i]) begin
                ones++;
                if (lowest < 0) lowest = i;
            end
        end
        for (int i = 0; i < NumDecoders; i++) begin
            slice = randomEntry();
            slice[EntryWidth-1 -: 12] = (i == lowest) ? opc : ~opc;
            dec_data_i[i*EntryWidth +: EntryWidth] = slice;
            if (i == lowest) chosen = slice;
        end
        dec_enable_i = en;
        flush_i = flush;
        ready_i = ready;
        reset_i = rst;
        if (rst) begin
            modelQ.delete();
            modelOvf = 1'b0;
            modelCol = 1'b0;
        end else begin
`ifdef DECODE_OUTPUT_QUEUE_COLLISION_CHECK_EN
            willPush = (ones == 1);
            if (ones > 1) modelCol = 1'b1;
`else
            willPush = (ones >= 1);
`endif
            if (flush) begin
                modelQ.delete();
            end else begin
                popNow  = (modelQ.size() > 0) && ready;
                fullNow = (modelQ.size() == Depth);
                if (willPush && fullNow && !popNow) modelOvf = 1'b1;
                if (popNow) void'(modelQ.pop_front());
                if (willPush && (!fullNow || popNow)) modelQ.push_back(chosen);
            end
        end
        @(posedge clock_i);
        #1;
    endtask

    // Compare every DUT output against the reference model.
    task automatic checkModel(input string tag);
        int sz;
        sz = modelQ.size();
        checkOutput({tag, ".count"}, EntryWidth'(count_o), EntryWidth'(sz));
        checkOutput({tag, ".valid"}, EntryWidth'(valid_o), EntryWidth'(sz != 0));
        checkOutput({tag, ".stall"}, EntryWidth'(stall_o), EntryWidth'(sz >= Depth - StallMargin));
        checkOutput({tag, ".overflow"}, EntryWidth'(overflow_o), EntryWidth'(modelOvf));
        checkOutput({tag, ".collision"}, EntryWidth'(collision_o), EntryWidth'(modelCol));
        if (sz != 0) checkOutput({tag, ".data"}, data_o, modelQ[0]);
    endtask

    task automatic addVec(input logic [NumDecoders-1:0] en, input logic [11:0] opc,
                          input logic flush, input logic ready, input logic rst,
                          input int expCount, input logic expStall, input logic expOvf,
                          input logic chkHead, input logic [11:0] expHead, input logic expZero);
        vec_t v;
        v.en = en; v.opc = opc; v.flush = flush; v.ready = ready; v.rst = rst;
        v.expCount = expCount; v.expStall = expStall; v.expOvf = expOvf; v.expCol = 1'b0;
        v.chkHead = chkHead; v.expHead = expHead; v.expZeroData = expZero;
        vecs.push_back(v);
    endtask

    initial begin
        logic [NumDecoders-1:0] en;
        compared = 0;
        mismatched = 0;
        modelOvf = 1'b0;
        modelCol = 1'b0;
        reset_i = 1'b1;
        flush_i = 1'b0;
        ready_i = 1'b0;
        dec_enable_i = '0;
        dec_data_i = '0;

        // Directed table: en, opc, flush, ready, rst, count, stall, overflow, chkHead, head, zeroData
        addVec(25'h0,       12'h000, 0, 0, 1, 0, 0, 0, 0, 12'h000, 1);
        addVec(25'h20,      12'h00E, 0, 0, 0, 1, 0, 0, 1, 12'h00E, 0);
        addVec(25'h80,      12'h101, 0, 0, 0, 2, 0, 0, 1, 12'h00E, 0);
        addVec(25'h1,       12'h102, 0, 0, 0, 3, 0, 0, 1, 12'h00E, 0);
        addVec(25'h1000000, 12'h103, 0, 0, 0, 4, 0, 0, 1, 12'h00E, 0);
        addVec(25'h400,     12'h104, 0, 0, 0, 5, 0, 0, 1, 12'h00E, 0);
        addVec(25'h20,      12'h105, 0, 0, 0, 6, 1, 0, 1, 12'h00E, 0);
        addVec(25'h2,       12'h106, 0, 0, 0, 7, 1, 0, 1, 12'h00E, 0);
        addVec(25'h8,       12'h107, 0, 0, 0, 8, 1, 0, 1, 12'h00E, 0);
        addVec(25'h10,      12'h108, 0, 0, 0, 8, 1, 1, 1, 12'h00E, 0);
        addVec(25'h20,      12'h109, 0, 1, 0, 8, 1, 1, 1, 12'h101, 0);
        addVec(25'h0,       12'h000, 0, 1, 0, 7, 1, 1, 1, 12'h102, 0);
        addVec(25'h0,       12'h000, 0, 1, 0, 6, 1, 1, 1, 12'h103, 0);
        addVec(25'h0,       12'h000, 0, 1, 0, 5, 0, 1, 1, 12'h104, 0);
        addVec(25'h0,       12'h000, 0, 1, 0, 4, 0, 1, 1, 12'h105, 0);
        addVec(25'h0,       12'h000, 0, 1, 0, 3, 0, 1, 1, 12'h106, 0);
        addVec(25'h0,       12'h000, 0, 1, 0, 2, 0, 1, 1, 12'h107, 0);
        addVec(25'h0,       12'h000, 0, 1, 0, 1, 0, 1, 1, 12'h109, 0);
        addVec(25'h0,       12'h000, 0, 1, 0, 0, 0, 1, 0, 12'h000, 0);
        addVec(25'h0,       12'h000, 0, 1, 0, 0, 0, 1, 0, 12'h000, 0);
        addVec(25'h4,       12'h201, 0, 0, 0, 1, 0, 1, 1, 12'h201, 0);
        addVec(25'h40,      12'h202, 0, 0, 0, 2, 0, 1, 1, 12'h201, 0);
        addVec(25'h100,     12'h203, 0, 0, 0, 3, 0, 1, 1, 12'h201, 0);
        addVec(25'h20,      12'h204, 1, 0, 0, 0, 0, 1, 0, 12'h000, 0);
`ifdef DECODE_OUTPUT_QUEUE_COLLISION_CHECK_EN
        addVec(25'h24,      12'h2AA, 0, 0, 0, 0, 0, 1, 0, 12'h000, 0);
`else
        addVec(25'h24,      12'h2AA, 0, 0, 0, 1, 0, 1, 1, 12'h2AA, 0);
`endif
        addVec(25'h20,      12'h2BB, 0, 1, 0, 1, 0, 1, 1, 12'h2BB, 0);
        addVec(25'h8,       12'h2C0, 0, 0, 0, 2, 0, 1, 1, 12'h2BB, 0);
        addVec(25'h8,       12'h2C1, 0, 0, 0, 3, 0, 1, 1, 12'h2BB, 0);
        addVec(25'h8,       12'h2C2, 0, 0, 0, 4, 0, 1, 1, 12'h2BB, 0);
        addVec(25'h8,       12'h2C3, 0, 0, 0, 5, 0, 1, 1, 12'h2BB, 0);
        addVec(25'h20,      12'h2D0, 0, 1, 1, 0, 0, 0, 0, 12'h000, 1);
        for (int i = 24; i <= 29; i++) vecs[i].expCol = ColOn;

        $display("[TB] directed table: %0d vectors", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].en, vecs[i].opc, vecs[i].flush, vecs[i].ready, vecs[i].rst);
            checkOutput($sformatf("vec%0d.count", i), EntryWidth'(count_o), EntryWidth'(vecs[i].expCount));
            checkOutput($sformatf("vec%0d.valid", i), EntryWidth'(valid_o), EntryWidth'(vecs[i].expCount != 0));
            checkOutput($sformatf("vec%0d.stall", i), EntryWidth'(stall_o), EntryWidth'(vecs[i].expStall));
            checkOutput($sformatf("vec%0d.overflow", i), EntryWidth'(overflow_o), EntryWidth'(vecs[i].expOvf));
            checkOutput($sformatf("vec%0d.collision", i), EntryWidth'(collision_o), EntryWidth'(vecs[i].expCol));
            if (vecs[i].chkHead)
                checkOutput($sformatf("vec%0d.opcode", i), EntryWidth'(entryOpcode(data_o)), EntryWidth'(vecs[i].expHead));
            if (vecs[i].expZeroData)
                checkOutput($sformatf("vec%0d.dataZero", i), data_o, '0);
            checkModel($sformatf("vec%0d.model", i));
        end

        $display("[TB] randomized traffic: %0d cycles", RandomCycles);
        for (int c = 0; c < RandomCycles; c++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            en = '0;
            if (sel >= 4 && sel <= 8) begin
                en[$urandom_range(0, NumDecoders - 1)] = 1'b1;
            end else if (sel == 9) begin
                en[$urandom_range(0, NumDecoders - 1)] = 1'b1;
                en[$urandom_range(0, NumDecoders - 1)] = 1'b1;
            end
            applyStimulus(en, 12'($urandom()),
                          $urandom_range(0, 29) == 0,
                          $urandom_range(0, 4) < 2,
                          $urandom_range(0, 199) == 0);
            checkModel($sformatf("rand%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/decode_output_queue.md
# decode_output_queue

Collects the registered outputs of the format-specific decoders (D, DS, X, XO, …), of which at most one is valid per cycle, and buffers them in an in-order FIFO toward the issue stage. It back-pressures the decoders through a stall signal with a margin sized for their one-cycle output latency. It also records overflow and, optionally, enable collisions. It sits directly downstream of the format decoder bank and upstream of issue/rename.

## Interface
Parameters:
- NumDecoders, 25 — number of format decoders feeding the queue; one enable bit per instruction format.
- EntryWidth, 229 — width of one decoded-instruction entry; layout is given in Operation.
- Depth, 8 — number of FIFO entries; must be a power of two and at least 4.
- StallMargin, 2 — free slots held in reserve when stall_o is raised.

Ports:
- clock_i  in  1 — the single clock.
- reset_i  in  1 — synchronous, active-high reset.
- dec_enable_i  in  NumDecoders — per-decoder enable_o bits; bit i belongs to decoder i.
- dec_data_i  in  NumDecoders*EntryWidth — concatenated entries; decoder i occupies slice [i*EntryWidth +: EntryWidth].
- flush_i  in  1 — discard every queued entry (mispredict or exception).
- stall_o  out  1 — stall request to all format decoders (drives their stall_i).
- valid_o  out  1 — head entry is valid.
- ready_i  in  1 — downstream accepts the head entry.
- data_o  out  EntryWidth — head entry.
- count_o  out  clog2(Depth+1) — current occupancy.
- overflow_o  out  1 — sticky flag: an input was dropped because the queue was full.
- collision_o  out  1 — sticky flag: more than one enable was seen in the same cycle; active only with the macro.

## Operation
- Entry field order, MSB first:
  - opcode 12, instruction address 64, functional unit 3, major ID 64, minor ID 7, numMicroOps 7, is64Bit 1, PID 20, TID 16, op1rw 2, op2rw 2;
  - op1isReg 1, op2isReg 1, immIsExtended 1, immIsShifted 1, modifiesCR 1, body 26.
  - Total 229 bits.
- Input select: when the enable vector is one-hot, the matching slice is chosen. A zero vector means no push.
- Push: happens when any enable is set, flush_i=0, and either count<Depth or a pop occurs in the same cycle.
- Drop on full: an input arriving while full with no pop is discarded and overflow_o is set.
- Pop: happens when valid_o && ready_i.
- FWFT: data_o shows the head entry combinationally from storage. valid_o = (count != 0).
- Pointers: read and write pointers are log2(Depth) bits and wrap naturally. count tracks occupancy separately, so no extra wrap bit is needed.
- flush_i:
  - Next cycle, count=0 and both pointers are 0.
  - Takes priority over push and pop in the same cycle; the input is dropped without setting overflow.
  - Sticky flags are unaffected.
- stall_o = (count >= Depth − StallMargin), combinational from the registered count.
- Sticky flags clear only on reset.
- Ordering is strict FIFO. Entries are never reordered or modified.

## Timing
- Reset (synchronous): count, pointers, overflow_o and collision_o go to 0. valid_o=0, stall_o=0, data_o=0 (storage cleared).
- Reset mid-operation behaves like a flush and also clears the sticky flags.
- Latency: an entry pushed in cycle t is visible on valid_o/data_o in cycle t+1 when the queue was empty; there is no bypass.
- Push and pop in the same cycle leave count unchanged, including when the queue is full and when count=1.
- Pop with count=0 is ignored.
- StallMargin=2 absorbs the decoder's registered output plus one instruction already accepted while stall_o propagates.

## Configuration
- DECODE_OUTPUT_QUEUE_COLLISION_CHECK_EN defined:
  - A multi-hot enable vector pushes nothing and sets collision_o.
- Macro not defined:
  - A multi-hot enable vector selects the lowest set index and pushes normally.
  - collision_o is tied to 0.

## Structure
- Package decode_queue_pkg holds:
  - the field widths (opcode, address, major ID, minor ID, PID, TID, body);
  - the derived EntryWidth and the field offset constants;
  - the unit IDs: FX=0, FP=1, VX=2, CR=3, LS=4, Branch=6.
- Sub-module decode_input_select: priority/one-hot mux from the enable vector and data bus to a single push valid, push data and collision flag. It is purely combinational.
- The top level holds the storage array, pointers, count and flags.

## Test plan
- Reset, then decoder 5 (the D format) pushes an entry with opcode 0x00E → valid_o=1 the next cycle, data_o opcode field = 0x00E, count_o=1.
- Push 6 entries with ready_i=0 → stall_o rises at the cycle count_o reaches 6. Two further pushes are accepted (count 8). A ninth push sets overflow_o; count stays 8.
- Queue full, simultaneous push and pop with ready_i=1 → count stays 8, the head advances, and the 9 entries come out in order over 9 pops.
- Queue holding 3 entries, flush_i=1 together with an enable → next cycle count=0, valid_o=0, overflow_o unchanged.
- Enables 0x000_0024 (bits 2 and 5 set):
  - with the macro: no push and collision_o=1;
  - without it: decoder 2's entry is pushed.
- Reset asserted while count=5 with overflow_o=1 → next cycle every output is 0.
